// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, line-state encoding and bit-period derivation.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per line bit, truncated toward zero.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered status flags and a sticky drop flag.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       head_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic             pop;

  // Accept/drop decisions use the registered flags, so a pop never frees room for a same-edge push.
  always_comb begin
    push       = wr_en && !full_q;
    pop        = rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only observed once written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_c   = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO front end feeding an 8N1 serialiser.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   data_in,
  input  logic                   wr_en,
  output logic                   tx,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW           = $clog2(DATA_BITS);

  uart_state_e            state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   pop_c;
  logic                   bit_end_c;
  logic [DATA_BITS-1:0]   fifo_head_c;
  logic                   fifo_empty;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (data_in),
    .wr_en    (wr_en),
    .rd_en    (pop_c),
    .head_c   (fifo_head_c),
    .full     (full),
    .empty    (fifo_empty),
    .count    (count),
    .overflow (overflow)
  );

  // Next-state logic: pop in IDLE, then time out start, eight data bits and stop.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_c     = 1'b0;
    bit_end_c = (timer_q == TW'(CLKS_PER_BIT - 1));
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_head_c;
          timer_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later, keeping tx glitch-free.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench: a default-rate instance (434 clocks/bit) and a fast one (4 clocks/bit).
module tb_uart_tx_buf;

  localparam int CPB0 = 434;
  localparam int CPB1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a   [2];
  logic       wr_a    [2];
  logic [7:0] din_a   [2];
  logic       tx_a    [2];
  logic       full_a  [2];
  logic       empty_a [2];
  logic       busy_a  [2];
  logic       ovf_a   [2];
  logic [4:0] cnt_a   [2];

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  logic [7:0] exp_q   [2][$];
  longint     start_q [2][$];

  uart_tx_buf u_dut_def (
    .clk      (clk),
    .rst      (rst_a[0]),
    .data_in  (din_a[0]),
    .wr_en    (wr_a[0]),
    .tx       (tx_a[0]),
    .full     (full_a[0]),
    .empty    (empty_a[0]),
    .count    (cnt_a[0]),
    .busy     (busy_a[0]),
    .overflow (ovf_a[0])
  );

  uart_tx_buf #(
    .CLK_HZ (460800),
    .BAUD   (115200),
    .DEPTH  (16)
  ) u_dut_fast (
    .clk      (clk),
    .rst      (rst_a[1]),
    .data_in  (din_a[1]),
    .wr_en    (wr_a[1]),
    .tx       (tx_a[1]),
    .full     (full_a[1]),
    .empty    (empty_a[1]),
    .count    (cnt_a[1]),
    .busy     (busy_a[1]),
    .overflow (ovf_a[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Status word order: tx, full, empty, busy, overflow, count[4:0].
  task automatic chk_st(input string name, input int id, input logic etx, input logic efull,
                        input logic eempty, input int ecnt, input logic ebusy, input logic eovf);
    chk(name, 32'({tx_a[id], full_a[id], empty_a[id], busy_a[id], ovf_a[id], cnt_a[id]}),
              32'({etx, efull, eempty, ebusy, eovf, 5'(ecnt)}));
  endtask

  // Receiver model: every sample of every bit must match the expected 8N1 shape.
  task automatic monitor(input int id, input int cpb);
    logic [9:0] frm;
    logic [7:0] eb;
    logic [7:0] rx;
    int         errs;
    bit         abort;
    bit         unexp;
    forever begin
      @(negedge clk);
      if (rst_a[id] !== 1'b1 && tx_a[id] === 1'b0) begin
        start_q[id].push_back(cyc);
        unexp = (exp_q[id].size() == 0);
        eb    = unexp ? 8'h00 : exp_q[id].pop_front();
        frm   = {1'b1, eb, 1'b0};
        errs  = 0;
        rx    = '0;
        abort = 1'b0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < cpb && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_a[id] === 1'b1) begin
              abort = 1'b1;
            end else begin
              if (tx_a[id] !== frm[b]) errs++;
              if (b >= 1 && b <= 8 && c == cpb / 2) rx[b-1] = tx_a[id];
            end
          end
        end
        if (!abort) begin
          total++;
          if (unexp || errs != 0 || rx !== eb) begin
            bad++;
            $display("FAIL frame dut%0d: got byte 0x%02h with %0d off-shape samples, expected byte 0x%02h%s",
                     id, rx, errs, eb, unexp ? " (nothing queued)" : "");
          end
        end
      end
    end
  endtask

  initial monitor(0, CPB0);
  initial monitor(1, CPB1);

  task automatic drive(input int id, input logic [7:0] b, input bit acc);
    wr_a[id]  = 1'b1;
    din_a[id] = b;
    if (acc) exp_q[id].push_back(b);
    @(negedge clk);
  endtask

  task automatic release_wr(input int id);
    wr_a[id]  = 1'b0;
    din_a[id] = 8'hA5;
  endtask

  task automatic wait_idle(input int id, input int budget, input string name, output longint done);
    int n = 0;
    while ((exp_q[id].size() != 0 || busy_a[id] !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    done = cyc;
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s timeout: %0d bytes still pending, busy=%b after %0d cycles",
               name, exp_q[id].size(), busy_a[id], n);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic longint take_start(input int id);
    if (start_q[id].size() == 0) return -1;
    return start_q[id].pop_front();
  endfunction

  initial begin
    longint p, s1, s2, done;
    int     n;
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1;
      wr_a[i]  = 1'b0;
      din_a[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_a[0] = 1'b0;
    rst_a[1] = 1'b0;
    chk_st("reset_def", 0, 1, 0, 1, 0, 0, 0);
    chk_st("reset_fast", 1, 1, 0, 1, 0, 0, 0);

    // Single 0x41 frame at default rate.
    drive(0, 8'h41, 1);
    p = cyc;
    release_wr(0);
    chk_st("push_accept", 0, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk_st("idle_pop", 0, 1, 0, 1, 0, 1, 0);
    wait_idle(0, 6000, "single_frame", done);
    s1 = take_start(0);
    chk("tx_fall_latency", 32'(s1 - p), 32'd2);
    chk("frame_len", 32'(done - p), 32'(2 + 10 * CPB0 - 1));
    chk_st("single_done", 0, 1, 0, 1, 0, 0, 0);

    // Back-to-back 0x47, 0x55 at default rate.
    drive(0, 8'h47, 1);
    p = cyc;
    drive(0, 8'h55, 1);
    release_wr(0);
    wait_idle(0, 10000, "b2b_frames", done);
    s1 = take_start(0);
    s2 = take_start(0);
    chk("b2b_first_latency", 32'(s1 - p), 32'd2);
    chk("b2b_gap", 32'(s2 - s1), 32'(10 * CPB0 + 1));
    chk_st("b2b_done", 0, 1, 0, 1, 0, 0, 0);

    // Fast rate: 0x00 then 0xFF, second push lands on the IDLE pop edge.
    drive(1, 8'h00, 1);
    p = cyc;
    chk_st("fast_push1", 1, 1, 0, 0, 1, 0, 0);
    drive(1, 8'hFF, 1);
    release_wr(1);
    chk_st("simul_push_pop", 1, 1, 0, 0, 1, 1, 0);
    wait_idle(1, 300, "fast_frames", done);
    s1 = take_start(1);
    s2 = take_start(1);
    chk("fast_latency", 32'(s1 - p), 32'd2);
    chk("fast_gap", 32'(s2 - s1), 32'(10 * CPB1 + 1));
    chk("fast_end", 32'(done - p), 32'(2 + 2 * 10 * CPB1));

    // Overflow: 18 consecutive pushes, the 18th is dropped.
    for (int i = 0; i < 18; i++) begin
      drive(1, 8'(8'h10 + i), i < 17);
      if (i == 16) chk_st("fill_full", 1, 0, 1, 0, 16, 1, 0);
      if (i == 17) chk_st("overflow_set", 1, 0, 1, 0, 16, 1, 1);
    end
    release_wr(1);
    wait_idle(1, 2000, "overflow_drain", done);
    chk_st("overflow_sticky", 1, 1, 0, 1, 0, 0, 1);
    chk("overflow_frames", 32'(start_q[1].size()), 32'd17);
    start_q[1].delete();
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    chk_st("overflow_cleared", 1, 1, 0, 1, 0, 0, 0);

    // Reset during data bit 3 with four bytes queued.
    for (int i = 0; i < 5; i++) drive(1, 8'(8'hC0 + i), 1);
    release_wr(1);
    n = 0;
    while (start_q[1].size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_frame_started", 32'(start_q[1].size()), 32'd1);
    s1 = (start_q[1].size() > 0) ? start_q[1][0] : cyc;
    n = 0;
    while (cyc < s1 + 16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_st("before_abort", 1, 0, 0, 0, 4, 1, 0);
    rst_a[1] = 1'b1;
    @(negedge clk);
    chk_st("reset_abort", 1, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_a[1] = 1'b0;
    exp_q[1].delete();
    start_q[1].delete();
    repeat (100) @(negedge clk);
    chk("no_frame_after_reset", 32'(start_q[1].size()), 32'd0);
    chk_st("quiet_after_reset", 1, 1, 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
